// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks onto the slot-0 frame sync and steers each
// sample into its per-channel output register, flagging sync errors.
module tdm_demux_ch #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         we_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)     q_q <= '0;
        else if (we_i) q_q <= d_i;
    end

    assign q_o = q_q;
endmodule

module tdm_demux #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int SB = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [W-1:0]   d_i,
    input  logic           dv_i,
    input  logic           fs_i,
    input  logic           eclr_i,
    output logic [N*W-1:0] y_o,
    output logic [N-1:0]   yv_o,
    output logic           fdone_o,
    output logic           lock_o,
    output logic           err_o
);
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SB-1:0] slot_q, slot_d;
    logic [N-1:0]  yv_q, yv_d;
    logic          fdone_q, fdone_d;
    logic          err_q, err_d;
    logic          wr;
    logic [SB-1:0] wsel;
    logic          err_set;
    logic          last;

    assign last = (slot_q == SB'(N - 1));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        fdone_d = 1'b0;
        wr      = 1'b0;
        wsel    = '0;
        err_set = 1'b0;
        if (dv_i) begin
            if (state_q == HUNT) begin
                if (fs_i) begin
                    wr      = 1'b1;
                    slot_d  = SB'(1);
                    state_d = LOCKED;
                end
            end else if (fs_i && slot_q != '0) begin
                // Early sync: abort the frame and restart it at this sample.
                err_set = 1'b1;
                wr      = 1'b1;
                slot_d  = SB'(1);
            end else if (!fs_i && slot_q == '0) begin
                err_set = 1'b1;
                slot_d  = '0;
                state_d = HUNT;
            end else begin
                wr      = 1'b1;
                wsel    = slot_q;
                fdone_d = last;
                slot_d  = last ? '0 : slot_q + SB'(1);
            end
        end
        yv_d = '0;
        if (wr) yv_d[wsel] = 1'b1;
        // A new error in the same cycle as eclr wins.
        err_d = err_set ? 1'b1 : (eclr_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= HUNT;
            slot_q  <= '0;
            yv_q    <= '0;
            fdone_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            yv_q    <= yv_d;
            fdone_q <= fdone_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_ch
        tdm_demux_ch #(.W(W)) u_ch (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .we_i  (wr && wsel == SB'(k)),
            .d_i   (d_i),
            .q_o   (y_o[k*W +: W])
        );
    end

    assign yv_o    = yv_q;
    assign fdone_o = fdone_q;
    assign lock_o  = (state_q == LOCKED);
    assign err_o   = err_q;
endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: a frame-level reference model queues the
// expected outputs per cycle and a monitor compares them after each edge.
module tb_tdm_demux;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SB = 2;

    logic           clk = 1'b0;
    logic           rst, dv, fs, eclr;
    logic [W-1:0]   d;
    logic [N*W-1:0] y;
    logic [N-1:0]   yv;
    logic           fdone, lock, err;

    always #5 clk = ~clk;

    tdm_demux #(.W(W), .N(N), .SB(SB)) dut (
        .clk_i(clk), .rst_i(rst), .d_i(d), .dv_i(dv), .fs_i(fs), .eclr_i(eclr),
        .y_o(y), .yv_o(yv), .fdone_o(fdone), .lock_o(lock), .err_o(err)
    );

    typedef struct {
        logic [N*W-1:0] y;
        logic [N-1:0]   yv;
        logic           fdone;
        logic           lock;
        logic           err;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference model state: channel contents, lock flag, next expected slot.
    int m_ch[N];
    bit m_locked;
    int m_slot;
    bit m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input bit r, input bit v, input bit f, input int dd, input bit ec);
        exp_t e;
        bit   eset;
        @(negedge clk);
        rst = r; dv = v; fs = f; d = W'(dd); eclr = ec;
        e.yv = '0; e.fdone = 1'b0; eset = 1'b0;
        if (r) begin
            foreach (m_ch[i]) m_ch[i] = 0;
            m_locked = 0; m_slot = 0; m_err = 0;
        end else begin
            if (v) begin
                if (!m_locked) begin
                    if (f) begin
                        m_ch[0] = dd & 8'hff; e.yv[0] = 1'b1; m_locked = 1; m_slot = 1;
                    end
                end else if (f && m_slot != 0) begin
                    eset = 1; m_ch[0] = dd & 8'hff; e.yv[0] = 1'b1; m_slot = 1;
                end else if (!f && m_slot == 0) begin
                    eset = 1; m_locked = 0;
                end else begin
                    m_ch[m_slot] = dd & 8'hff;
                    e.yv[m_slot] = 1'b1;
                    e.fdone = (m_slot == N - 1);
                    m_slot = (m_slot + 1) % N;
                end
            end
            if (eset) m_err = 1;
            else if (ec) m_err = 0;
        end
        for (int i = 0; i < N; i++) e.y[i*W +: W] = W'(m_ch[i]);
        e.lock = m_locked;
        e.err  = m_err;
        q.push_back(e);
    endtask

    task automatic frame(input int b0, input int b1, input int b2, input int b3);
        step(0, 1, 1, b0, 0);
        step(0, 1, 0, b1, 0);
        step(0, 1, 0, b2, 0);
        step(0, 1, 0, b3, 0);
    endtask

    task automatic at_edge_chk(input string name, input logic [63:0] exp);
        @(posedge clk); #2;
        chk(name, 64'(y), exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("y", 64'(y), 64'(e.y));
                chk("yv", 64'(yv), 64'(e.yv));
                chk("fdone", 64'(fdone), 64'(e.fdone));
                chk("lock", 64'(lock), 64'(e.lock));
                chk("err", 64'(err), 64'(e.err));
            end
        end
    end

    initial begin : stim
        rst = 1; dv = 0; fs = 0; eclr = 0; d = '0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // Clean frames.
        frame('h11, 'h22, 'h33, 'h44);
        at_edge_chk("clean_f1", 64'h44332211);
        frame('h55, 'h66, 'h77, 'h88);
        at_edge_chk("clean_f2", 64'h88776655);
        // HUNT discard.
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 'hAA, 0);
        step(0, 1, 0, 'hBB, 0);
        frame('h01, 'h02, 'h03, 'h04);
        at_edge_chk("hunt", 64'h04030201);
        // Gaps in dv.
        step(0, 1, 1, 'h11, 0); step(0, 0, 1, 'hEE, 0);
        step(0, 1, 0, 'h22, 0); step(0, 0, 0, 'hEE, 0); step(0, 0, 1, 'hEE, 0);
        step(0, 1, 0, 'h33, 0); step(0, 0, 0, 'hEE, 0);
        step(0, 1, 0, 'h44, 0); step(0, 0, 0, 'hEE, 0);
        at_edge_chk("gaps", 64'h44332211);
        // Early sync, then clear.
        step(0, 1, 1, 'h11, 0);
        step(0, 1, 0, 'h22, 0);
        frame('h99, 'h10, 'h20, 'h30);
        at_edge_chk("early", 64'h30201099);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        // Missing sync, then relock; also eclr colliding with a new error.
        frame('h11, 'h22, 'h33, 'h44);
        step(0, 1, 0, 'h55, 1);
        at_edge_chk("missing", 64'h44332211);
        step(0, 1, 1, 'h66, 0);
        at_edge_chk("relock", 64'h44332266);
        step(0, 0, 0, 0, 1);
        // Reset mid-frame.
        step(0, 1, 0, 'h77, 0);
        step(1, 1, 0, 'h88, 0);
        at_edge_chk("midrst", 64'h0);
        step(0, 1, 0, 'h12, 0);
        step(0, 1, 1, 'h34, 0);
        at_edge_chk("after_rst", 64'h34);
        // Randomized traffic, mostly well framed.
        for (int i = 0; i < 400; i++) begin
            bit v, f, r, ec;
            v  = ($urandom_range(0, 3) != 0);
            f  = (m_locked && m_slot == 0) ? ($urandom_range(0, 7) != 0)
                                           : ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 99) == 0);
            ec = ($urandom_range(0, 9) == 0);
            step(r, v, f, int'($urandom_range(0, 255)), ec);
        end
        step(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
